// File: rtl/rggen_apb_master.sv
// APB4 initiator bridge from the rggen local command/response interface.
// Optional ACCESS timeout: define RGGEN_APB_MASTER_TIMEOUT_EN.
module rggen_apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_command_valid,
  output logic                     o_command_ready,
  input  logic                     i_write,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  input  logic [DATA_WIDTH-1:0]    i_write_mask,
  input  logic [2:0]               i_pprot,
  output logic                     o_response_valid,
  output logic [DATA_WIDTH-1:0]    o_read_data,
  output logic [1:0]               o_status,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic                     o_pwrite,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic [DATA_WIDTH-1:0]    o_pwdata,
  output logic [DATA_WIDTH/8-1:0]  o_pstrb,
  input  logic                     i_pready,
  input  logic                     i_pslverr,
  input  logic [DATA_WIDTH-1:0]    i_prdata
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e                   state_q, state_d;
  logic                     pwrite_q, pwrite_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic [SW-1:0]            pstrb_q, pstrb_d;
  logic [2:0]               pprot_q, pprot_d;
  logic                     rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               status_q, status_d;
  logic [SW-1:0]            strb;
  logic                     ready;

`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          limit;

  // Abort on the wait cycle that would bring the count to the limit
  assign limit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign ready = (state_q == IDLE) && !rst;

  always_comb begin
    strb = '0;
    for (int i = 0; i < SW; i++) begin
      strb[i] = i_write && (|i_write_mask[8*i+:8]);
    end
  end

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    status_d = status_q;
`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_command_valid && ready) begin
          state_d  = SETUP;
          pwrite_d = i_write;
          paddr_d  = i_address;
          pwdata_d = i_write_data;
          pstrb_d  = strb;
          pprot_d  = i_pprot;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        if (i_pready) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = (!pwrite_q && !i_pslverr) ? i_prdata : '0;
          status_d = {1'b0, i_pslverr};
`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
        end else if (limit) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          status_d = 2'b11;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  assign o_command_ready  = ready;
  assign o_psel           = (state_q != IDLE);
  assign o_penable        = (state_q == ACCESS);
  assign o_pwrite         = pwrite_q;
  assign o_paddr          = paddr_q;
  assign o_pwdata         = pwdata_q;
  assign o_pstrb          = pstrb_q;
  assign o_pprot          = pprot_q;
  assign o_response_valid = rvalid_q;
  assign o_read_data      = rdata_q;
  assign o_status         = status_q;

endmodule

// File: tb/tb_rggen_apb_master.sv
// Directed bench for rggen_apb_master (default 32-bit data, 16-bit address).
// Timeout scenario runs when RGGEN_APB_MASTER_TIMEOUT_EN is defined.
module tb_rggen_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_command_valid;
  logic        o_command_ready;
  logic        i_write;
  logic [15:0] i_address;
  logic [31:0] i_write_data;
  logic [31:0] i_write_mask;
  logic [2:0]  i_pprot;
  logic        o_response_valid;
  logic [31:0] o_read_data;
  logic [1:0]  o_status;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [15:0] o_paddr;
  logic [2:0]  o_pprot;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic        i_pready;
  logic        i_pslverr;
  logic [31:0] i_prdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rggen_apb_master #(
    .DATA_WIDTH     (32),
    .ADDRESS_WIDTH  (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_command_valid  (i_command_valid),
    .o_command_ready  (o_command_ready),
    .i_write          (i_write),
    .i_address        (i_address),
    .i_write_data     (i_write_data),
    .i_write_mask     (i_write_mask),
    .i_pprot          (i_pprot),
    .o_response_valid (o_response_valid),
    .o_read_data      (o_read_data),
    .o_status         (o_status),
    .o_psel           (o_psel),
    .o_penable        (o_penable),
    .o_pwrite         (o_pwrite),
    .o_paddr          (o_paddr),
    .o_pprot          (o_pprot),
    .o_pwdata         (o_pwdata),
    .o_pstrb          (o_pstrb),
    .i_pready         (i_pready),
    .i_pslverr        (i_pslverr),
    .i_prdata         (i_prdata)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a command in the current cycle; returns in the response cycle
  task automatic xfer(
    input logic        wr,
    input logic [15:0] addr,
    input logic [31:0] wd,
    input logic [31:0] mask,
    input logic [2:0]  prot,
    input logic [3:0]  strb,
    input int          waits,
    input logic [31:0] rd,
    input logic        slv,
    input logic [31:0] exp_rd,
    input logic [1:0]  exp_st,
    input logic        keep_valid
  );
    int psel_n;
    i_command_valid = 1'b1;
    i_write         = wr;
    i_address       = addr;
    i_write_data    = wd;
    i_write_mask    = mask;
    i_pprot         = prot;
    chk("cmd_ready", o_command_ready, 1);
    @(negedge clk);
    if (!keep_valid) i_command_valid = 1'b0;
    chk("setup_psel", o_psel, 1);
    chk("setup_penable", o_penable, 0);
    chk("setup_pwrite", o_pwrite, wr);
    chk("setup_paddr", o_paddr, addr);
    chk("setup_pwdata", o_pwdata, wd);
    chk("setup_pstrb", o_pstrb, strb);
    chk("setup_pprot", o_pprot, prot);
    chk("setup_ready", o_command_ready, 0);
    chk("setup_rvalid", o_response_valid, 0);
    i_pready  = 1'b1;
    i_pslverr = 1'b1;
    i_prdata  = 32'h7777_7777;
    psel_n    = 1;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      psel_n += int'(o_psel);
      chk("acc_penable", o_penable, 1);
      chk("acc_paddr", o_paddr, addr);
      chk("acc_pstrb", o_pstrb, strb);
      chk("acc_rvalid", o_response_valid, 0);
      i_pready  = (k == waits);
      i_prdata  = rd;
      i_pslverr = slv;
    end
    @(negedge clk);
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    i_prdata  = '0;
    chk("resp_valid", o_response_valid, 1);
    chk("resp_rdata", o_read_data, exp_rd);
    chk("resp_status", o_status, exp_st);
    chk("resp_psel", o_psel, 0);
    chk("resp_ready", o_command_ready, 1);
    chk("psel_cycles", psel_n, waits + 2);
    chk("idle_paddr", o_paddr, addr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    i_command_valid = 1'b0;
    i_write         = 1'b0;
    i_address       = '0;
    i_write_data    = '0;
    i_write_mask    = '0;
    i_pprot         = '0;
    i_pready        = 1'b0;
    i_pslverr       = 1'b0;
    i_prdata        = '0;
    repeat (2) @(negedge clk);
    chk("rst_psel", o_psel, 0);
    chk("rst_penable", o_penable, 0);
    chk("rst_pwrite", o_pwrite, 0);
    chk("rst_rvalid", o_response_valid, 0);
    chk("rst_paddr", o_paddr, 0);
    chk("rst_pwdata", o_pwdata, 0);
    chk("rst_pstrb", o_pstrb, 0);
    chk("rst_pprot", o_pprot, 0);
    chk("rst_rdata", o_read_data, 0);
    chk("rst_status", o_status, 0);
    chk("rst_ready", o_command_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", o_command_ready, 1);
    @(negedge clk);

    xfer(1'b1, 16'h0010, 32'hA5A5_0F0F, 32'h0000_FFFF, 3'b010, 4'b0011,
         0, 32'hDEAD_BEEF, 1'b0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    chk("rvalid_one_cycle", o_response_valid, 0);
    xfer(1'b0, 16'h0020, 32'h1111_1111, 32'hFFFF_FFFF, 3'b001, 4'b0000,
         3, 32'h1234_5678, 1'b0, 32'h1234_5678, 2'b00, 1'b0);
    @(negedge clk);
    xfer(1'b0, 16'h0030, 32'h0, 32'h0, 3'b000, 4'b0000,
         1, 32'hFFFF_FFFF, 1'b1, 32'h0, 2'b01, 1'b0);
    @(negedge clk);
    xfer(1'b1, 16'h0100, 32'hCAFE_F00D, 32'hFF00_0080, 3'b111, 4'b1001,
         0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b1);
    xfer(1'b0, 16'h0104, 32'h0, 32'h0, 3'b000, 4'b0000,
         2, 32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, 2'b00, 1'b0);
    @(negedge clk);
    xfer(1'b1, 16'hFFFE, 32'h0, 32'h00FF_0000, 3'b100, 4'b0100,
         1, 32'h5555_AAAA, 1'b1, 32'h0, 2'b01, 1'b0);
    @(negedge clk);

`ifdef RGGEN_APB_MASTER_TIMEOUT_EN
    i_command_valid = 1'b1;
    i_write         = 1'b0;
    i_address       = 16'h0300;
    @(negedge clk);
    i_command_valid = 1'b0;
    chk("to_setup_psel", o_psel, 1);
    i_pready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("to_acc_penable", o_penable, 1);
      chk("to_acc_rvalid", o_response_valid, 0);
      i_prdata = 32'h9999_9999;
    end
    @(negedge clk);
    chk("to_rvalid", o_response_valid, 1);
    chk("to_status", o_status, 2'b11);
    chk("to_rdata", o_read_data, 0);
    chk("to_psel", o_psel, 0);
    chk("to_penable", o_penable, 0);
    @(negedge clk);
    xfer(1'b0, 16'h0304, 32'h0, 32'h0, 3'b000, 4'b0000,
         0, 32'h4242_4242, 1'b0, 32'h4242_4242, 2'b00, 1'b0);
`else
    xfer(1'b0, 16'h0040, 32'h0, 32'h0, 3'b011, 4'b0000,
         20, 32'h600D_F00D, 1'b0, 32'h600D_F00D, 2'b00, 1'b0);
`endif
    @(negedge clk);

    i_command_valid = 1'b1;
    i_write         = 1'b1;
    i_address       = 16'h0200;
    i_write_data    = 32'h1357_9BDF;
    i_write_mask    = 32'hFFFF_FFFF;
    i_pprot         = 3'b001;
    @(negedge clk);
    i_command_valid = 1'b0;
    chk("rs_setup_psel", o_psel, 1);
    @(negedge clk);
    chk("rs_acc_penable", o_penable, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_psel", o_psel, 0);
    chk("rs_penable", o_penable, 0);
    chk("rs_rvalid", o_response_valid, 0);
    chk("rs_paddr", o_paddr, 0);
    chk("rs_ready_in_rst", o_command_ready, 0);
    i_pready = 1'b1;
    rst      = 1'b0;
    #1;
    chk("rs_ready_after", o_command_ready, 1);
    @(negedge clk);
    chk("rs_no_resp", o_response_valid, 0);
    chk("rs_idle_psel", o_psel, 0);
    i_pready = 1'b0;
    xfer(1'b0, 16'h0208, 32'h0, 32'h0, 3'b000, 4'b0000,
         0, 32'hA0B0_C0D0, 1'b0, 32'hA0B0_C0D0, 2'b00, 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
